// File: rtl/aq_fcnvt_xtoh_ctrl.sv
// FP64 -> FP16 convert sequencer: captures one operand, classifies it, drives the shared
// denormal shifter and rounds/packs the half-precision result with IEEE exception flags.
module aq_fcnvt_xtoh_ctrl #(
  parameter int unsigned RM_W = 3
) (
  input  logic            forever_cpuclk,
  input  logic            cpurst,
  input  logic            ctrl_flush,
  input  logic            req_vld,
  output logic            req_rdy,
  input  logic [63:0]     req_src,
  input  logic [RM_W-1:0] req_rm,
  output logic [11:0]     xtoh_sh_cnt,
  output logic [51:0]     xtoh_sh_src,
  input  logic [10:0]     xtoh_sh_f_v,
  input  logic [53:0]     xtoh_sh_f_x,
  output logic            res_vld,
  input  logic            res_rdy,
  output logic [15:0]     res_data,
  output logic [4:0]      res_fflags
);

  typedef enum logic [1:0] {StIdle, StCalc, StRnd, StDone} state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [63:0]     r_src;
  logic [RM_W-1:0] r_rm;
  logic [9:0]      r_fv;
  logic            r_guard_sh;
  logic            r_sticky_sh;
  logic            r_vld;
  logic [15:0]     r_data;
  logic [4:0]      r_flags;

  logic w_accept;

  assign req_rdy  = ~ctrl_flush & ((r_state == StIdle) | ((r_state == StDone) & res_rdy));
  assign w_accept = req_vld & req_rdy;

  // Operand classification, shared by CALC and RND.
  logic               w_sign;
  logic [10:0]        w_exp;
  logic [51:0]        w_frac;
  logic signed [11:0] w_e;
  logic               w_exp_max;
  logic               w_frac_nz;
  logic               w_nan;
  logic               w_inf;
  logic               w_zero;
  logic               w_denorm;
  logic               w_ovf_pre;
  logic               w_tiny;

  assign w_sign    = r_src[63];
  assign w_exp     = r_src[62:52];
  assign w_frac    = r_src[51:0];
  assign w_e       = $signed({1'b0, w_exp}) - 12'sd1023;
  assign w_exp_max = (w_exp == 11'h7FF);
  assign w_frac_nz = (w_frac != 52'd0);
  assign w_nan     = w_exp_max & w_frac_nz;
  assign w_inf     = w_exp_max & ~w_frac_nz;
  assign w_zero    = (w_exp == 11'd0) & ~w_frac_nz;
  assign w_denorm  = (w_exp == 11'd0) & w_frac_nz;
  assign w_ovf_pre = ~w_exp_max & (w_e > 12'sd15);
  assign w_tiny    = w_denorm | ((w_exp != 11'd0) & (w_e <= -12'sd15));

  // Shifter is only driven while its result is being sampled.
  always_comb begin
    xtoh_sh_cnt = 12'd0;
    xtoh_sh_src = 52'd0;
    if (r_state == StCalc) begin
      xtoh_sh_src = w_frac;
      if (w_denorm) begin
        xtoh_sh_cnt = 12'h800;
      end else if (w_tiny) begin
        xtoh_sh_cnt = w_e;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: if (w_accept) w_state_nxt = StCalc;
      StCalc: w_state_nxt = StRnd;
      StRnd:  w_state_nxt = StDone;
      StDone: if (res_rdy) w_state_nxt = w_accept ? StCalc : StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (ctrl_flush) w_state_nxt = StIdle;
  end

  // Rounding inputs: tiny values take the shifter result, normals the raw fraction.
  logic [9:0] w_mant;
  logic [4:0] w_exp5;
  logic       w_guard;
  logic       w_sticky;
  logic       w_inexact;
  logic       w_inc;

  always_comb begin
    w_mant   = w_frac[51:42];
    w_exp5   = w_e[4:0] + 5'd15;
    w_guard  = w_frac[41];
    w_sticky = |w_frac[40:0];
    if (w_tiny) begin
      w_mant   = r_fv;
      w_exp5   = 5'd0;
      w_guard  = r_guard_sh;
      w_sticky = r_sticky_sh;
    end
  end

  assign w_inexact = w_guard | w_sticky;

  // Encodings 5..7 fall through to round-to-nearest-even.
  always_comb begin
    w_inc = w_guard & (w_sticky | w_mant[0]);
    if (r_rm == RM_W'(1)) begin
      w_inc = 1'b0;
    end else if (r_rm == RM_W'(2)) begin
      w_inc = w_sign & w_inexact;
    end else if (r_rm == RM_W'(3)) begin
      w_inc = ~w_sign & w_inexact;
    end else if (r_rm == RM_W'(4)) begin
      w_inc = w_guard;
    end
  end

  // Mantissa carry ripples into the exponent field, covering denormal->normal and binade steps.
  logic [14:0] w_sum;
  logic        w_ovf;
  logic [14:0] w_ovf_mag;

  assign w_sum = {w_exp5, w_mant} + {14'd0, w_inc};
  assign w_ovf = w_ovf_pre | (w_sum[14:10] == 5'h1F);

  always_comb begin
    w_ovf_mag = 15'h7C00;
    if (r_rm == RM_W'(1)) begin
      w_ovf_mag = 15'h7BFF;
    end else if (r_rm == RM_W'(2)) begin
      w_ovf_mag = w_sign ? 15'h7C00 : 15'h7BFF;
    end else if (r_rm == RM_W'(3)) begin
      w_ovf_mag = w_sign ? 15'h7BFF : 15'h7C00;
    end
  end

  logic [15:0] w_res_data;
  logic [4:0]  w_res_flags;

  always_comb begin
    w_res_data  = {w_sign, w_sum};
    w_res_flags = {3'b000, w_tiny & w_inexact, w_inexact};
    if (w_nan) begin
      w_res_data  = 16'h7E00;
      w_res_flags = {~w_frac[51], 4'b0000};
    end else if (w_inf) begin
      w_res_data  = {w_sign, 15'h7C00};
      w_res_flags = 5'b00000;
    end else if (w_zero) begin
      w_res_data  = {w_sign, 15'h0000};
      w_res_flags = 5'b00000;
    end else if (w_ovf) begin
      w_res_data  = {w_sign, w_ovf_mag};
      w_res_flags = 5'b00101;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_state     <= StIdle;
      r_src       <= 64'd0;
      r_rm        <= '0;
      r_fv        <= 10'd0;
      r_guard_sh  <= 1'b0;
      r_sticky_sh <= 1'b0;
      r_vld       <= 1'b0;
      r_data      <= 16'd0;
      r_flags     <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_src <= req_src;
        r_rm  <= req_rm;
      end
      if (r_state == StCalc) begin
        r_fv        <= xtoh_sh_f_v[9:0];
        r_guard_sh  <= xtoh_sh_f_x[53];
        r_sticky_sh <= |xtoh_sh_f_x[52:0];
      end
      if (ctrl_flush) begin
        r_vld <= 1'b0;
      end else if (r_state == StRnd) begin
        r_vld   <= 1'b1;
        r_data  <= w_res_data;
        r_flags <= w_res_flags;
      end else if ((r_state == StDone) && res_rdy) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign res_vld    = r_vld;
  assign res_data   = r_data;
  assign res_fflags = r_flags;

  // Half denormals never need the shifter's integer bit.
  logic w_unused_fv;
  assign w_unused_fv = xtoh_sh_f_v[10];

endmodule
